// File: rtl/axis_fifo_pkg.sv
// Shared helpers for the level-reporting stream FIFO.
// The payload struct lives in the module because only it can see DATA_WIDTH.
package axis_fifo_pkg;

   function automatic int lvl_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// Ring pointer that wraps at DEPTH-1 and flips a phase bit on every wrap,
// so equal pointers can be told apart as empty (same phase) or full.
module fifo_wrap_ptr #(
   parameter int DEPTH = 16,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          inc_i,
   output logic [PW-1:0] ptr_o,
   output logic          phase_o
);

   localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

   // DEPTH need not be a power of two, so the wrap is an explicit compare.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         ptr_o   <= '0;
         phase_o <= 1'b0;
      end else if (inc_i) begin
         if (ptr_o == LAST_IDX) begin
            ptr_o   <= '0;
            phase_o <= ~phase_o;
         end else begin
            ptr_o <= ptr_o + PW'(1);
         end
      end
   end

endmodule

// File: rtl/axis_fifo_level.sv
// First-word fall-through stream FIFO with TLAST, occupancy and almost flags.
// Define AXIS_FIFO_PACKET_EN to hold valid_o until a whole packet is stored.
module axis_fifo_level
   import axis_fifo_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int DEPTH         = 16,
   parameter int AFULL_THRESH  = DEPTH - 2,
   parameter int AEMPTY_THRESH = 2,
   localparam int LW = lvl_width(DEPTH),
   localparam int PW = $clog2(DEPTH)
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   input  logic                  last_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   output logic [DATA_WIDTH-1:0] data_o,
   output logic                  last_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [LW-1:0]         level_o,
   output logic                  almost_full_o,
   output logic                  almost_empty_o
);

   typedef struct packed {
      logic                  last;
      logic [DATA_WIDTH-1:0] data;
   } entry_t;

   entry_t          mem [DEPTH];
   entry_t          rd_entry;
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic            wr_phase;
   logic            rd_phase;
   logic            full;
   logic            empty;
   logic            push;
   logic            pop;

   fifo_wrap_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (push),
      .ptr_o   (wr_ptr),
      .phase_o (wr_phase)
   );

   fifo_wrap_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .inc_i   (pop),
      .ptr_o   (rd_ptr),
      .phase_o (rd_phase)
   );

   assign full  = (wr_ptr == rd_ptr) && (wr_phase != rd_phase);
   assign empty = (wr_ptr == rd_ptr) && (wr_phase == rd_phase);
   assign push  = valid_i & ready_o;
   assign pop   = valid_o & ready_i;

   // Storage is deliberately left unreset; stale entries are unreachable.
   always_ff @(posedge clk_i) begin
      if (push && !rst_i) begin
         mem[wr_ptr] <= '{last: last_i, data: data_i};
      end
   end

   assign rd_entry = mem[rd_ptr];
   assign data_o   = rd_entry.data;
   assign last_o   = rd_entry.last;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         level_o <= '0;
      end else begin
         case ({push, pop})
            2'b10:   level_o <= level_o + LW'(1);
            2'b01:   level_o <= level_o - LW'(1);
            default: level_o <= level_o;
         endcase
      end
   end

`ifdef AXIS_FIFO_PACKET_EN
   logic [LW-1:0] pkt_cnt;
   logic          pkt_in;
   logic          pkt_out;

   assign pkt_in  = push & last_i;
   assign pkt_out = pop & last_o;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pkt_cnt <= '0;
      end else begin
         case ({pkt_in, pkt_out})
            2'b10:   pkt_cnt <= pkt_cnt + LW'(1);
            2'b01:   pkt_cnt <= pkt_cnt - LW'(1);
            default: pkt_cnt <= pkt_cnt;
         endcase
      end
   end

   // The full override lets a packet longer than DEPTH drain instead of deadlocking.
   assign valid_o = ~empty & ((pkt_cnt != '0) | full);
`else
   assign valid_o = ~empty;
`endif

   assign ready_o        = ~full;
   assign almost_full_o  = (level_o >= LW'(AFULL_THRESH));
   assign almost_empty_o = (level_o <= LW'(AEMPTY_THRESH));

endmodule
